// File: rtl/axi4_burst_read_engine_if.sv
// AXI4 read-address and read-data channel bundle for the DMA read engine.
// The optional rresp field exists only when DMA_RD_ERR_EN is defined.
interface axi4_burst_read_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
`ifdef DMA_RD_ERR_EN
  logic [1:0]        rresp;
`endif

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rlast
`ifdef DMA_RD_ERR_EN
    , input rresp
`endif
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rlast
`ifdef DMA_RD_ERR_EN
    , output rresp
`endif
  );
endinterface

// File: rtl/axi4_burst_read_engine.sv
// DMA read-side AXI4 master: INCR bursts of up to MAX_BURST beats, split at 4KB pages,
// each beat pushed into the DMA FIFO. Optional read-error handling under DMA_RD_ERR_EN.
module axi4_burst_read_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_read,
  input  logic [LEN_W-1:0]              r_size_data,
  input  logic [ADDR_W-1:0]             raddr_reg,
  output logic                          read_done,
  output logic                          busy,
  input  logic                          fifo_full,
  output logic                          wen,
  output logic [DATA_W-1:0]             data_in,
`ifdef DMA_RD_ERR_EN
  output logic                          read_err,
`endif
  axi4_burst_read_engine_if.master      axi
);
  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = $clog2(BYTES);
  localparam int CNT_W = LEN_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  addr_reg;
  logic [CNT_W-1:0]   remaining_reg;
  logic [8:0]         burst_reg;
  logic [8:0]         beat_reg;
  logic               arvalid_reg;
  logic [ADDR_W-1:0]  araddr_reg;
  logic [7:0]         arlen_reg;
  logic               err_reg;

  logic [CNT_W-1:0]   size_beats;
  logic [12:0]        page_beats;
  logic [8:0]         burst_calc;
  logic               rready_c;
  logic               wen_c;
  logic               beat_acc;
  logic               bad_beat;
  logic               last_beat;

  assign size_beats = CNT_W'(({1'b0, r_size_data} + CNT_W'(BYTES - 1)) >> SHIFT);
  assign page_beats = (13'd4096 - {1'b0, addr_reg[11:0]}) >> SHIFT;
  assign last_beat  = (beat_reg == burst_reg - 9'd1);

  // Burst length: smallest of what is left, the burst cap and the beats to the 4KB page end.
  always_comb begin
    burst_calc = 9'(MAX_BURST);
    if (32'(page_beats) < 32'(burst_calc))
      burst_calc = 9'(page_beats);
    if (32'(remaining_reg) < 32'(burst_calc))
      burst_calc = 9'(remaining_reg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    rready_c   = 1'b0;
    wen_c      = 1'b0;
    beat_acc   = 1'b0;
    bad_beat   = 1'b0;
    case (state_reg)
      IDLE: if (start_read) state_next = (size_beats == '0) ? DONE : AR;
      AR:   if (arvalid_reg && axi.arready) state_next = R;
      R: begin
`ifdef DMA_RD_ERR_EN
        // After an error the rest of the burst is drained regardless of FIFO space.
        rready_c = !fifo_full || err_reg;
`else
        rready_c = !fifo_full;
`endif
        beat_acc = axi.rvalid && rready_c;
        if (beat_acc) begin
`ifdef DMA_RD_ERR_EN
          bad_beat = axi.rresp[1];
          wen_c    = !bad_beat && !err_reg;
`else
          wen_c    = 1'b1;
`endif
          if (last_beat)
            state_next = (remaining_reg == CNT_W'(burst_reg) || err_reg || bad_beat) ? DONE : AR;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      burst_reg     <= '0;
      beat_reg      <= '0;
      arvalid_reg   <= 1'b0;
      araddr_reg    <= '0;
      arlen_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start_read) begin
          addr_reg      <= raddr_reg & ALIGN_MASK;
          remaining_reg <= size_beats;
          err_reg       <= 1'b0;
        end
        AR: begin
          // First AR cycle captures the burst; arvalid rises on the next one and holds.
          if (!arvalid_reg) begin
            arvalid_reg <= 1'b1;
            araddr_reg  <= addr_reg;
            arlen_reg   <= 8'(burst_calc - 9'd1);
            burst_reg   <= burst_calc;
            beat_reg    <= '0;
          end else if (axi.arready) begin
            arvalid_reg <= 1'b0;
          end
        end
        R: if (beat_acc) begin
          beat_reg <= beat_reg + 9'd1;
          if (bad_beat)
            err_reg <= 1'b1;
          if (last_beat) begin
            addr_reg      <= addr_reg + (ADDR_W'(burst_reg) << SHIFT);
            remaining_reg <= remaining_reg - CNT_W'(burst_reg);
          end
        end
        default: ;
      endcase
    end
  end

  assign axi.arvalid = arvalid_reg;
  assign axi.araddr  = araddr_reg;
  assign axi.arlen   = arlen_reg;
  assign axi.arsize  = 3'(SHIFT);
  assign axi.arburst = 2'b01;
  assign axi.rready  = rready_c;
  assign wen         = wen_c;
  assign data_in     = (state_reg == R) ? axi.rdata : '0;
  assign read_done   = (state_reg == DONE);
  assign busy        = (state_reg == AR) || (state_reg == R);
`ifdef DMA_RD_ERR_EN
  assign read_err    = err_reg;
  logic unused_sig;
  assign unused_sig  = axi.rlast ^ axi.rresp[0];
`else
  logic unused_sig;
  assign unused_sig  = axi.rlast ^ err_reg;
`endif
endmodule

// File: tb/tb_axi4_burst_read_engine.sv
// Self-checking bench for axi4_burst_read_engine: directed and random transfers against
// a burst/beat list model; reactive AXI slave with memory word = A0000000 + addr/4.
module tb_axi4_burst_read_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_read;
  logic [15:0] r_size_data;
  logic [31:0] raddr_reg;
  logic        read_done;
  logic        busy;
  logic        fifo_full;
  logic        wen;
  logic [31:0] data_in;
`ifdef DMA_RD_ERR_EN
  logic        read_err;
`endif

  axi4_burst_read_engine_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi4_burst_read_engine #(.ADDR_W(32), .DATA_W(32), .LEN_W(16), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst), .start_read(start_read), .r_size_data(r_size_data),
    .raddr_reg(raddr_reg), .read_done(read_done), .busy(busy), .fifo_full(fifo_full),
    .wen(wen), .data_in(data_in),
`ifdef DMA_RD_ERR_EN
    .read_err(read_err),
`endif
    .axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int len; } ar_t;
  ar_t         exp_ar[$];
  logic [31:0] exp_data[$];
  int errors = 0, checks = 0;
  int pend_beats, xfer_beat, err_idx = -1, ff_trig = -1, ff_hold, done_cnt;
  bit err_seen, rand_mode, r_hs, ar_wait;
  logic [31:0] pend_addr, prev_araddr;
  logic [7:0]  prev_arlen;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: split the transfer into bursts and list the words that must reach the FIFO.
  task automatic build_model(input logic [31:0] a, input int size, input int eidx);
    logic [31:0] base;
    int rem, b, pg, idx;
    bit stop;
    base = a & 32'hFFFF_FFFC;
    rem = (size + 3) / 4;
    idx = 0;
    stop = 0;
    exp_ar.delete();
    exp_data.delete();
    while (rem > 0 && !stop) begin
      pg = (4096 - int'(base % 4096)) / 4;
      b = rem;
      if (b > 16) b = 16;
      if (b > pg) b = pg;
      exp_ar.push_back('{addr: base, len: b - 1});
      for (int k = 0; k < b; k++) begin
        if (eidx < 0 || idx < eidx) exp_data.push_back(mem_word(base + 32'(4 * k)));
        idx++;
      end
      if (eidx >= 0 && idx > eidx) stop = 1;
      base += 32'(4 * b);
      rem -= b;
    end
    err_idx = eidx;
    xfer_beat = 0;
    err_seen = 0;
    done_cnt = 0;
  endtask

  // Slave drives at the falling edge, then samples what the next rising edge will transfer.
  always @(negedge clk) begin
    if (rst) begin
      axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rlast = 0;
`ifdef DMA_RD_ERR_EN
      axi.rresp = 2'b00;
`endif
      fifo_full = 0; pend_beats = 0; r_hs = 0; ar_wait = 0; ff_hold = 0;
    end else begin
      axi.arready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!(axi.rvalid && !r_hs)) begin
        if (pend_beats > 0) begin
          axi.rvalid = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
          axi.rdata  = mem_word(pend_addr);
          axi.rlast  = (pend_beats == 1);
`ifdef DMA_RD_ERR_EN
          axi.rresp  = (err_idx >= 0 && xfer_beat == err_idx) ? 2'b10 : 2'b00;
`endif
        end else begin
          axi.rvalid = 0;
        end
      end
      if (ff_hold > 0) begin
        fifo_full = 1;
        ff_hold--;
      end else begin
        fifo_full = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      #1;
      if (ar_wait) begin
        check("ar_hold_valid", axi.arvalid, 1);
        check("ar_hold_addr", axi.araddr, prev_araddr);
        check("ar_hold_len", axi.arlen, prev_arlen);
      end
      ar_wait = axi.arvalid && !axi.arready;
      prev_araddr = axi.araddr;
      prev_arlen = axi.arlen;
      if (fifo_full && !err_seen) begin
        check("full_rready", axi.rready, 0);
        check("full_wen", wen, 0);
      end
      if (axi.arvalid && axi.arready) begin
        check("one_outstanding", pend_beats, 0);
        check("ar_expected", exp_ar.size() != 0, 1);
        if (exp_ar.size() != 0) begin
          ar_t e;
          e = exp_ar.pop_front();
          check("araddr", axi.araddr, e.addr);
          check("arlen", axi.arlen, e.len);
        end
        check("arsize", axi.arsize, 2);
        check("arburst", axi.arburst, 1);
        pend_beats = int'(axi.arlen) + 1;
        pend_addr = axi.araddr;
      end
      r_hs = axi.rvalid && axi.rready;
      if (r_hs) begin
        check("beat_wen", wen, (err_idx < 0 || xfer_beat < err_idx));
        if (wen) begin
          check("data_expected", exp_data.size() != 0, 1);
          if (exp_data.size() != 0) check("data_in", data_in, exp_data.pop_front());
        end
`ifdef DMA_RD_ERR_EN
        if (axi.rresp[1]) err_seen = 1;
`endif
        xfer_beat++;
        pend_beats--;
        pend_addr += 4;
        if (ff_trig >= 0 && xfer_beat == ff_trig) ff_hold = 4;
      end else begin
        check("idle_wen", wen, 0);
      end
      if (read_done) done_cnt++;
    end
  end

  task automatic run_xfer(input logic [31:0] a, input int size, input int eidx,
                          input int fft, input bit busy_start);
    int cyc;
    build_model(a, size, eidx);
    ff_trig = fft;
    @(negedge clk); #2;
    start_read = 1; raddr_reg = a; r_size_data = 16'(size);
    @(negedge clk); #2;
    start_read = 0;
    if (size == 0) check("zero_done_next_cycle", read_done, 1);
    else           check("busy_after_start", busy, 1);
    if (busy_start) begin
      repeat (2) @(negedge clk);
      #2;
      check("busy_mid", busy, 1);
      start_read = 1; raddr_reg = 32'h0000_5550; r_size_data = 16'd40;
      @(negedge clk); #2;
      start_read = 0;
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 5000) begin
      @(negedge clk); #2;
      cyc++;
    end
    check("done_seen", done_cnt != 0, 1);
    check("done_pulse", read_done, 1);
    check("busy_at_done", busy, 0);
`ifdef DMA_RD_ERR_EN
    check("read_err", read_err, (eidx >= 0 && eidx < (size + 3) / 4));
`endif
    @(negedge clk); #2;
    check("done_one_cycle", read_done, 0);
    check("done_count", done_cnt, 1);
    check("ar_left", exp_ar.size(), 0);
    check("beats_left", exp_data.size(), 0);
    $display("xfer addr=%08h size=%0d beats=%0d checks=%0d errors=%0d",
             a, size, xfer_beat, checks, errors);
    ff_trig = -1;
  endtask

  initial begin
    rst = 1; start_read = 0; r_size_data = 0; raddr_reg = 0; rand_mode = 0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_arvalid", axi.arvalid, 0);
    check("rst_araddr", axi.araddr, 0);
    check("rst_arlen", axi.arlen, 0);
    check("rst_arsize", axi.arsize, 2);
    check("rst_arburst", axi.arburst, 1);
    check("rst_rready", axi.rready, 0);
    check("rst_wen", wen, 0);
    check("rst_data_in", data_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", read_done, 0);
    rst = 0;

    run_xfer(32'h0000_0000, 12, -1, -1, 0);
    run_xfer(32'h0000_000A, 10, -1, -1, 0);
    run_xfer(32'h0000_0000, 80, -1, -1, 1);
    run_xfer(32'h0000_0FF8, 32, -1, -1, 0);
    run_xfer(32'h0000_0100, 64, -1, 3, 0);
    run_xfer(32'h0000_0040, 0, -1, -1, 0);
`ifdef DMA_RD_ERR_EN
    run_xfer(32'h0000_0000, 128, 1, -1, 0);
    run_xfer(32'h0000_0200, 16, -1, -1, 0);
`endif

    // Reset in the middle of a burst.
    build_model(32'h0000_0200, 64, -1);
    @(negedge clk); #2;
    start_read = 1; raddr_reg = 32'h0000_0200; r_size_data = 16'd64;
    @(negedge clk); #2;
    start_read = 0;
    repeat (6) @(negedge clk);
    #3;
    rst = 1;
    #1;
    check("midrst_arvalid", axi.arvalid, 0);
    check("midrst_rready", axi.rready, 0);
    check("midrst_wen", wen, 0);
    check("midrst_busy", busy, 0);
    check("midrst_arlen", axi.arlen, 0);
    repeat (2) @(negedge clk);
    #2;
    rst = 0;
    exp_ar.delete();
    exp_data.delete();
    run_xfer(32'h0000_0300, 20, -1, -1, 0);

    rand_mode = 1;
    for (int t = 0; t < 12; t++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'hF00 + 12'($urandom_range(0, 255));
      run_xfer(a, $urandom_range(0, 200), -1, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
